// File: rtl/midi_pkg.sv
// Shared MIDI definitions: line format constants and the UART receiver
// state encoding (also intended for the transmit side).
package midi_pkg;

    localparam int unsigned MIDI_BAUD      = 31_250;
    localparam int unsigned MIDI_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } midi_state_e;

endpackage

// File: rtl/midi_uart_rx_if.sv
// Received-byte channel: valid/ready handshake plus error pulses.
interface midi_uart_rx_if;
    import midi_pkg::*;

    logic [MIDI_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_err;
    logic                      overrun;

    // Receiver side drives data, valid and the error pulses.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    // Consumer side accepts bytes and observes the error pulses.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/midi_sync.sv
// Two-flop synchronizer with a configurable reset value, for asynchronous
// MIDI pins.
module midi_sync #(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next-state for the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, forced to the idle level on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI UART receiver: 8N1 deserializer with mid-bit sampling, start-bit
// glitch rejection, framing-error detection, a one-byte holding register
// and overrun signalling.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 16_000_000,
    parameter int unsigned BAUD        = MIDI_BAUD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           midi_in,
    midi_uart_rx_if.master rx
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(MIDI_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MIDI_DATA_BITS - 1);

    if (DIV < 16) begin : g_div_check
        $error("midi_uart_rx: CLK_FREQ_HZ / BAUD must be at least 16");
    end

    logic line_s;

    midi_state_e                state_q,    state_d;
    logic [CNT_W-1:0]           cnt_q,      cnt_d;
    logic [IDX_W-1:0]           bit_idx_q,  bit_idx_d;
    logic [MIDI_DATA_BITS-1:0]  shift_q,    shift_d;
    logic                       line_h_q,   line_h_d;
    logic [MIDI_DATA_BITS-1:0]  rx_data_q,  rx_data_d;
    logic                       rx_valid_q, rx_valid_d;
    logic                       frame_err_q, frame_err_d;
    logic                       overrun_q,  overrun_d;

    logic sample;
    logic byte_good;
    logic consume;

    midi_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (midi_in),
        .q   (line_s)
    );

    // Frame FSM, bit timer, shift register and holding-register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        line_h_d    = line_s;
        byte_good   = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        sample      = (cnt_q == '0);
        consume     = rx_valid_q && rx.rx_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (line_h_q && !line_s) begin
                    cnt_d   = CNT_HALF;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (sample) begin
                    if (line_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d     = CNT_FULL;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    // LSB arrives first, so shifting in at the top leaves
                    // bit[index] in place after the last data bit.
                    shift_d = {line_s, shift_q[MIDI_DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (sample) begin
                    if (line_s) begin
                        byte_good = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (line_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_WAIT_HIGH;
            end
        endcase

        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q && !consume;
        if (byte_good) begin
            if (!rx_valid_q || consume) begin
                rx_data_d  = shift_d;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_HIGH;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            line_h_q    <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            line_h_q    <= line_h_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx.rx_data   = rx_data_q;
    assign rx.rx_valid  = rx_valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;

endmodule
